// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO with one-cycle read latency into a
// valid/ready stream. A 2-entry skid buffer plus an in-flight flag keep the
// stream at full rate, and a beat counter marks BURST_LEN-beat bursts.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [7:0]       beat_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  // Entry 0 is always the head; entry 1 only holds data when occ_q == 2.
  logic [1:0][WIDTH-1:0] buf_q, buf_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [7:0]            beat_q, beat_d;

  logic [1:0] level;
  logic       pop, push;

  // Buffered words plus the word already requested; never exceeds 2.
  assign level   = occ_q + {1'b0, infl_q};
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[0];
  assign m_last  = m_valid & (beat_q == LAST_BEAT);
  assign beat_cnt = beat_q;

  // Flush freezes the stream: no pop, and returning read data is dropped.
  assign pop  = m_valid & m_ready & ~flush;
  assign push = infl_q & ~flush;

  // Issue a read only when the word has guaranteed room on arrival: either a
  // slot is free, or the buffer is full-with-inflight but the head leaves now.
  // Gating on fifo_empty here keeps us independent of the FIFO's own guard.
  assign fifo_ren = ~fifo_empty & ~flush & rst_n &
                    ((level <= 2'd1) | ((level == 2'd2) & m_valid & m_ready));

  // Next-state for buffer, occupancy, in-flight flag and burst position.
  always_comb begin
    buf_d  = buf_q;
    occ_d  = occ_q;
    infl_d = fifo_ren;
    beat_d = beat_q;
    if (flush) begin
      occ_d  = 2'd0;
      infl_d = 1'b0;
      beat_d = 8'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          buf_d[occ_q[0]] = fifo_rdata;
          occ_d           = occ_q + 2'd1;
        end
        2'b01: begin
          buf_d[0] = buf_q[1];
          occ_d    = occ_q - 2'd1;
        end
        2'b11: begin
          // occ stays put; the new word lands behind whatever remains.
          if (occ_q == 2'd2) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = fifo_rdata;
          end else begin
            buf_d[0] = fifo_rdata;
          end
        end
        default: ;
      endcase
      if (pop) beat_d = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
    end
  end

  // State registers; reset clears data storage as well as control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      beat_q <= 8'd0;
    end else begin
      buf_q  <= buf_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (BURST_LEN 16, 5, 1), each fed by
// a simple array-backed sync FIFO model with one-cycle read latency.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;
  int checks = 0;
  int passes = 0;
  int ren_viol = 0;
  int inv_viol = 0;

  // instance 0: BURST_LEN=16, instance 1: BURST_LEN=5, instance 2: BURST_LEN=1
  logic fe0, ren0, mv0, ml0;
  logic fe1, ren1, mv1, ml1;
  logic fe2, ren2, mv2, ml2;
  logic mr0, mr1, mr2;
  logic [7:0] rd0 = '0, rd1 = '0, rd2 = '0;
  logic [7:0] md0, md1, md2, bc0, bc1, bc2;

  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  logic [7:0] mem2 [4096];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

  assign fe0 = (wp0 == rp0);
  assign fe1 = (wp1 == rp1);
  assign fe2 = (wp2 == rp2);

  always @(posedge clk) if (ren0) begin rd0 <= mem0[rp0]; rp0 <= rp0 + 1; end
  always @(posedge clk) if (ren1) begin rd1 <= mem1[rp1]; rp1 <= rp1 + 1; end
  always @(posedge clk) if (ren2) begin rd2 <= mem2[rp2]; rp2 <= rp2 + 1; end

  fifo_rd_stream #(.WIDTH(8), .BURST_LEN(16)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe0), .fifo_ren(ren0), .fifo_rdata(rd0),
    .flush(flush), .m_valid(mv0), .m_ready(mr0), .m_data(md0), .m_last(ml0), .beat_cnt(bc0));
  fifo_rd_stream #(.WIDTH(8), .BURST_LEN(5)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe1), .fifo_ren(ren1), .fifo_rdata(rd1),
    .flush(flush), .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_last(ml1), .beat_cnt(bc1));
  fifo_rd_stream #(.WIDTH(8), .BURST_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe2), .fifo_ren(ren2), .fifo_rdata(rd2),
    .flush(flush), .m_valid(mv2), .m_ready(mr2), .m_data(md2), .m_last(ml2), .beat_cnt(bc2));

  // Continuous watchers: read-while-empty and the occupancy bound.
  always @(negedge clk) begin
    if ((ren0 && fe0) || (ren1 && fe1) || (ren2 && fe2)) ren_viol++;
    if (int'(u1.occ_q) + int'(u1.infl_q) > 2) inv_viol++;
    if (int'(u0.occ_q) + int'(u0.infl_q) > 2) inv_viol++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push0(input logic [7:0] w); mem0[wp0] = w; wp0++; endtask
  task automatic push1(input logic [7:0] w); mem1[wp1] = w; wp1++; endtask
  task automatic push2(input logic [7:0] w); mem2[wp2] = w; wp2++; endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mv0, ml0, ren0, mv1, ml1, ren1, mv2, ml2, ren2} !== 9'b0) begin
      $display("FAIL reset_ctrl: got %b want 0", {mv0, ml0, ren0, mv1, ml1, ren1, mv2, ml2, ren2});
    end else passes++;
    checks++;
    if (bc0 !== 8'd0 || md0 !== 8'd0) $display("FAIL reset_data: beat %0d data %0h want 0/0", bc0, md0);
    else passes++;
    cyc(); cyc();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 16; i++) push0(8'(i));
    #1;
    checks++;
    if (ren0 !== 1'b0) $display("FAIL ren_in_reset: got %b want 0", ren0);
    else passes++;
    rst_n = 1'b1;
    mr0 = 1'b1;
    #1;
    checks++;
    if (ren0 !== 1'b1) $display("FAIL ren_after_release: got %b want 1", ren0);
    else passes++;
    cyc();
    checks++;
    if (mv0 !== 1'b0) $display("FAIL stream_latency: valid %b after 1 edge want 0", mv0);
    else passes++;
    cyc();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mv0 !== 1'b1 || md0 !== 8'(i + 1) || bc0 !== 8'(i) || ml0 !== (i == 15))
        $display("FAIL stream_beat%0d: v%b d%0h b%0d l%b want v1 d%0h b%0d l%b",
                 i, mv0, md0, bc0, ml0, 8'(i + 1), i, (i == 15));
      else passes++;
      cyc();
    end
    checks++;
    if (mv0 !== 1'b0 || ren_viol != 0) $display("FAIL stream_end: valid %b ren_viol %0d want 0/0", mv0, ren_viol);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] a [4];
    int got;
    mr0 = 1'b0;
    for (int i = 0; i < 4; i++) begin a[i] = 8'($urandom); push0(a[i]); end
    repeat (10) cyc();
    checks++;
    if (u0.occ_q !== 2'd2 || u0.infl_q !== 1'b0 || ren0 !== 1'b0 || mv0 !== 1'b1 || md0 !== a[0])
      $display("FAIL bp_hold: occ %0d infl %b ren %b v %b d %0h want 2 0 0 1 %0h",
               u0.occ_q, u0.infl_q, ren0, mv0, md0, a[0]);
    else passes++;
    mr0 = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (mv0) begin
        checks++;
        if (md0 !== a[got] || bc0 !== 8'(got))
          $display("FAIL bp_beat%0d: d %0h b %0d want %0h %0d", got, md0, bc0, a[got], got);
        else passes++;
        got++;
      end
      cyc();
    end
    repeat (2) cyc();
    checks++;
    if (got != 4 || mv0 !== 1'b0) $display("FAIL bp_count: got %0d beats valid %b want 4 beats valid 0", got, mv0);
    else passes++;
  endtask

  task automatic test_flush();
    logic [7:0] w [3];
    // Buffer holding one word with a second in flight: the in-flight word must be dropped.
    mr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin w[i] = 8'($urandom); push0(w[i]); end
    cyc(); cyc();
    checks++;
    if (u0.occ_q !== 2'd1 || u0.infl_q !== 1'b1) $display("FAIL flush_setup: occ %0d infl %b want 1 1", u0.occ_q, u0.infl_q);
    else passes++;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    checks++;
    if (mv0 !== 1'b0 || bc0 !== 8'd0 || u0.occ_q !== 2'd0 || u0.infl_q !== 1'b0)
      $display("FAIL flush_clear: v %b b %0d occ %0d infl %b want 0 0 0 0", mv0, bc0, u0.occ_q, u0.infl_q);
    else passes++;
    mr0 = 1'b1;
    for (int c = 0; c < 10 && !mv0; c++) cyc();
    checks++;
    if (mv0 !== 1'b1 || md0 !== w[2] || bc0 !== 8'd0)
      $display("FAIL flush_next: v %b d %0h b %0d want 1 %0h 0", mv0, md0, bc0, w[2]);
    else passes++;
    cyc();
    // Full buffer, with ready high during the flush cycle: nothing accepted or counted.
    mr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin w[i] = 8'($urandom); push0(w[i]); end
    repeat (4) cyc();
    checks++;
    if (u0.occ_q !== 2'd2 || bc0 !== 8'd1) $display("FAIL flush2_setup: occ %0d b %0d want 2 1", u0.occ_q, bc0);
    else passes++;
    flush = 1'b1;
    mr0 = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    checks++;
    if (mv0 !== 1'b0 || bc0 !== 8'd0) $display("FAIL flush2_clear: v %b b %0d want 0 0", mv0, bc0);
    else passes++;
    for (int c = 0; c < 10 && !mv0; c++) cyc();
    checks++;
    if (mv0 !== 1'b1 || md0 !== w[2] || bc0 !== 8'd0)
      $display("FAIL flush2_next: v %b d %0h b %0d want 1 %0h 0", mv0, md0, bc0, w[2]);
    else passes++;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_w;
    mr0 = 1'b1;
    for (int i = 0; i < 12; i++) push0(8'($urandom));
    for (int c = 0; c < 40 && !(mv0 && bc0 == 8'd7); c++) cyc();
    checks++;
    if (mv0 !== 1'b1 || bc0 !== 8'd7) $display("FAIL rstmid_reach: v %b b %0d want 1 7", mv0, bc0);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mv0, ml0, ren0} !== 3'b0 || bc0 !== 8'd0 || md0 !== 8'd0)
      $display("FAIL rstmid_async: v%b l%b r%b b %0d d %0h want all 0", mv0, ml0, ren0, bc0, md0);
    else passes++;
    cyc(); cyc();
    exp_w = mem0[rp0];
    checks++;
    if (rp0 >= wp0) $display("FAIL rstmid_left: fifo words left %0d want >0", wp0 - rp0);
    else passes++;
    rst_n = 1'b1;
    for (int c = 0; c < 10 && !mv0; c++) cyc();
    checks++;
    if (mv0 !== 1'b1 || bc0 !== 8'd0 || md0 !== exp_w)
      $display("FAIL rstmid_restart: v %b b %0d d %0h want 1 0 %0h", mv0, bc0, md0, exp_w);
    else passes++;
    repeat (12) cyc();
    checks++;
    if (mv0 !== 1'b0 || fe0 !== 1'b1) $display("FAIL rstmid_drain: v %b empty %b want 0 1", mv0, fe0);
    else passes++;
  endtask

  task automatic test_random();
    logic [7:0] sq [$];
    logic [7:0] w, prev_d;
    logic prev_stall;
    int sent, got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 8000 && got < 1000; c++) begin
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        w = 8'($urandom); push1(w); sq.push_back(w); sent++;
      end
      mr1 = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        checks++;
        if (mv1 !== 1'b1 || md1 !== prev_d) $display("FAIL rnd_hold: v %b d %0h want 1 %0h", mv1, md1, prev_d);
        else passes++;
      end
      prev_stall = mv1 && !mr1;
      prev_d = md1;
      if (mv1 && mr1) begin
        checks++;
        if (sq.size() == 0) $display("FAIL rnd_extra: beat %0d with d %0h, want no beat", got, md1);
        else if (md1 !== sq[0] || bc1 !== 8'(got % 5) || ml1 !== (got % 5 == 4))
          $display("FAIL rnd_beat%0d: d %0h b %0d l %b want %0h %0d %b",
                   got, md1, bc1, ml1, sq[0], got % 5, (got % 5 == 4));
        else passes++;
        if (sq.size() != 0) void'(sq.pop_front());
        got++;
      end
      cyc();
    end
    mr1 = 1'b0;
    checks++;
    if (got != 1000 || inv_viol != 0 || ren_viol != 0)
      $display("FAIL rnd_summary: beats %0d inv_viol %0d ren_viol %0d want 1000 0 0", got, inv_viol, ren_viol);
    else passes++;
  endtask

  task automatic test_burst1();
    logic [7:0] sq [$];
    logic [7:0] w;
    int got;
    got = 0;
    for (int i = 0; i < 8; i++) begin w = 8'($urandom); push2(w); sq.push_back(w); end
    for (int c = 0; c < 200 && got < 8; c++) begin
      mr2 = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ml2 !== mv2 || bc2 !== 8'd0) $display("FAIL b1_flags: v %b l %b b %0d want l=v b=0", mv2, ml2, bc2);
      else passes++;
      if (mv2 && mr2) begin
        checks++;
        if (md2 !== sq[0]) $display("FAIL b1_data%0d: d %0h want %0h", got, md2, sq[0]);
        else passes++;
        void'(sq.pop_front());
        got++;
      end
      cyc();
    end
    checks++;
    if (got != 8) $display("FAIL b1_count: beats %0d want 8", got);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    mr0 = 1'b0; mr1 = 1'b0; mr2 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    test_burst1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
